// File: rtl/vga_pkg.sv
// Shared VGA plot definitions: adapter geometry, pixel field widths, arbiter state encoding.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // idx + 1 wrapped to [0, n-1]; idx is always already below n
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        logic [3:0] s;
        s = {1'b0, idx} + 4'd1;
        return (s >= 4'(n)) ? 3'd0 : s[2:0];
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus shared by the drawing FSMs and the plot arbiter.
interface vga_plot_arbiter_if
    import vga_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         lock;
    logic [X_W*N_REQ-1:0]     req_x;
    logic [Y_W*N_REQ-1:0]     req_y;
    logic [COLOR_W*N_REQ-1:0] req_color;
    logic [N_REQ-1:0]         gnt;

    modport master (output req, lock, req_x, req_y, req_color, input gnt);
    modport slave  (input req, lock, req_x, req_y, req_color, output gnt);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] win,
    output logic [2:0]   win_idx,
    output logic         any
);
    logic [3:0] idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = {1'b0, ptr} + 4'(off);
            if (idx >= 4'(N)) idx = idx - 4'(N);
            if (!any && (|(req & (N'(1) << idx)))) begin
                win     = N'(1) << idx;
                win_idx = idx[2:0];
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin pixel-port arbiter with locked bursts and lock timeout.
// Optional off-screen clipping is enabled by defining VGA_ARB_CLIP_EN.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    vga_plot_arbiter_if.slave  bus,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot,
    output logic [2:0]         owner,
    output logic               owned,
    output logic [15:0]        clip_cnt
);
    arb_state_t         state, state_next;
    logic [2:0]         ptr, ptr_next, owner_next;
    logic [7:0]         idle_cnt, idle_cnt_next;
    logic [8:0]         idle_inc;
    logic [N_REQ-1:0]   pick_win, gnt_c, owner_oh;
    logic [2:0]         pick_idx;
    logic               pick_any, any_gnt, clip;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_c;

    rr_pick #(.N(N_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign owner_oh = N_REQ'(1) << owner;
    assign idle_inc = {1'b0, idle_cnt} + 9'd1;

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        owner_next    = owner;
        idle_cnt_next = idle_cnt;
        gnt_c         = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_c = pick_win;
                    if (|(bus.lock & pick_win)) begin
                        state_next    = OWNED;
                        owner_next    = pick_idx;
                        idle_cnt_next = '0;
                    end else begin
                        ptr_next = wrap_inc(pick_idx, N_REQ);
                    end
                end
            end
            OWNED: begin
                if (|(bus.req & owner_oh)) begin
                    gnt_c         = owner_oh;
                    idle_cnt_next = '0;
                end
                // Lock release wins over the timeout; the same-cycle grant still stands
                if (!(|(bus.lock & owner_oh))) begin
                    state_next = IDLE;
                    ptr_next   = wrap_inc(owner, N_REQ);
                end else if (!(|(bus.req & owner_oh))) begin
                    if (idle_inc >= 9'(LOCK_TIMEOUT)) begin
                        state_next    = IDLE;
                        ptr_next      = wrap_inc(owner, N_REQ);
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_inc[7:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            owner    <= owner_next;
            idle_cnt <= idle_cnt_next;
        end
    end

    assign bus.gnt = gnt_c;
    assign owned   = (state == OWNED);
    assign any_gnt = |gnt_c;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_x = bus.req_x[X_W*i +: X_W];
                sel_y = bus.req_y[Y_W*i +: Y_W];
                sel_c = bus.req_color[COLOR_W*i +: COLOR_W];
            end
        end
    end

`ifdef VGA_ARB_CLIP_EN
    assign clip = (sel_x >= X_W'(SCREEN_W)) || (sel_y >= Y_W'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (reset)
            clip_cnt <= '0;
        else if (any_gnt && clip && (clip_cnt != 16'hFFFF))
            clip_cnt <= clip_cnt + 16'd1;
    end
`else
    assign clip     = 1'b0;
    assign clip_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            vga_plot <= any_gnt && !clip;
            if (any_gnt && !clip) begin
                vga_x     <= sel_x;
                vga_y     <= sel_y;
                vga_color <= sel_c;
            end
        end
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus randomized requesters vs a reference model.
module tb_vga_plot_arbiter;
    import vga_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 255;
`ifdef VGA_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot;
    logic [2:0]  owner;
    logic        owned;
    logic [15:0] clip_cnt;

    always #10 clk = ~clk;

    vga_plot_arbiter_if #(.N_REQ(N)) bus ();

    vga_plot_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .owner     (owner),
        .owned     (owned),
        .clip_cnt  (clip_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: owner index or -1, rotating pointer, idle count, expected output regs
    int m_owner = -1, m_ptr = 0, m_idle = 0;
    int m_x = 0, m_y = 0, m_c = 0, m_plot = 0, m_clip = 0;

    int last_gnt, last_plot, last_x, last_y, last_c, last_owned, last_clip;
    bit pending [N];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic cycle();
        int win, nxt_owner, nxt_ptr, nxt_idle, px, py, pc;
        logic [23:0] tx;
        logic [20:0] ty;
        logic [8:0]  tc;
        @(negedge clk);
        last_gnt   = int'(bus.gnt);
        last_plot  = int'(vga_plot);
        last_x     = int'(vga_x);
        last_y     = int'(vga_y);
        last_c     = int'(vga_color);
        last_owned = int'(owned);
        last_clip  = int'(clip_cnt);

        win = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (win < 0 && bit_at(bus.req, (m_ptr + k) % N)) win = (m_ptr + k) % N;
        end else if (bit_at(bus.req, m_owner)) begin
            win = m_owner;
        end

        chk("gnt", last_gnt, (win < 0) ? 0 : (1 << win));
        chk("owned", last_owned, (m_owner >= 0) ? 1 : 0);
        if (m_owner >= 0) chk("owner", int'(owner), m_owner);
        chk("vga_plot", last_plot, m_plot);
        chk("vga_x", last_x, m_x);
        chk("vga_y", last_y, m_y);
        chk("vga_color", last_c, m_c);
        chk("clip_cnt", last_clip, m_clip);

        nxt_owner = m_owner;
        nxt_ptr   = m_ptr;
        nxt_idle  = m_idle;
        if (m_owner < 0) begin
            if (win >= 0) begin
                if (bit_at(bus.lock, win)) begin
                    nxt_owner = win;
                    nxt_idle  = 0;
                end else begin
                    nxt_ptr = (win + 1) % N;
                end
            end
        end else begin
            nxt_idle = (win >= 0) ? 0 : m_idle + 1;
            if (!bit_at(bus.lock, m_owner) || nxt_idle == TMO) begin
                nxt_owner = -1;
                nxt_ptr   = (m_owner + 1) % N;
                nxt_idle  = 0;
            end
        end

        if (reset) begin
            m_owner = -1; m_ptr = 0; m_idle = 0;
            m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_clip = 0;
        end else begin
            m_owner = nxt_owner; m_ptr = nxt_ptr; m_idle = nxt_idle;
            m_plot = 0;
            if (win >= 0) begin
                tx = bus.req_x >> (8 * win);
                ty = bus.req_y >> (7 * win);
                tc = bus.req_color >> (3 * win);
                px = int'(tx[7:0]);
                py = int'(ty[6:0]);
                pc = int'(tc[2:0]);
                if (CLIP && (px >= 160 || py >= 120)) begin
                    if (m_clip < 65535) m_clip++;
                end else begin
                    m_plot = 1;
                    m_x = px; m_y = py; m_c = pc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int i, input int x, input int y, input int c);
        bus.req_x[8*i +: 8]     = 8'(x);
        bus.req_y[7*i +: 7]     = 7'(y);
        bus.req_color[3*i +: 3] = 3'(c);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        reset         = 1'b1;
        bus.req       = '0;
        bus.lock      = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_color = '0;

        do_reset();
        cycle();
        chk("rst_gnt", last_gnt, 0);
        chk("rst_plot", last_plot, 0);
        chk("rst_owned", last_owned, 0);
        chk("rst_x", last_x, 0);

        // single requester
        set_px(1, 10, 20, 3);
        bus.req = 3'b010;
        cycle();
        chk("single_gnt", last_gnt, 2);
        bus.req = '0;
        cycle();
        chk("single_plot", last_plot, 1);
        chk("single_x", last_x, 10);
        chk("single_y", last_y, 20);
        chk("single_c", last_c, 3);
        cycle();
        chk("single_plot_off", last_plot, 0);

        // round robin
        do_reset();
        for (int i = 0; i < N; i++) set_px(i, 30 + i, 40 + i, i + 1);
        bus.req = 3'b111;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_gnt", last_gnt, 1 << (k % 3));
            cnt += last_plot;
        end
        bus.req = '0;
        cycle();
        cnt += last_plot;
        chk("rr_plots", cnt, 6);

        // locked burst
        do_reset();
        bus.req  = 3'b100;
        bus.lock = 3'b100;
        set_px(2, 50, 60, 5);
        cycle();
        cnt = (last_gnt == 4) ? 1 : 0;
        bus.req = 3'b111;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (last_gnt == 4 && last_owned == 1) cnt++;
        end
        chk("burst_grants", cnt, 16);
        bus.req  = 3'b011;
        bus.lock = 3'b000;
        cycle();
        chk("burst_drop_gnt", last_gnt, 0);
        cycle();
        chk("burst_after_owned", last_owned, 0);
        chk("burst_after_gnt", last_gnt, 1);

        // lock timeout
        do_reset();
        bus.req  = 3'b010;
        bus.lock = 3'b010;
        cycle();
        chk("tmo_first_gnt", last_gnt, 2);
        bus.req = 3'b100;
        cnt = 0;
        for (int k = 0; k < TMO; k++) begin
            cycle();
            cnt += (last_gnt != 0) ? 1 : 0;
        end
        chk("tmo_no_gnt", cnt, 0);
        chk("tmo_owned_last", last_owned, 1);
        cycle();
        chk("tmo_released", last_owned, 0);
        chk("tmo_gnt", last_gnt, 4);

        // clipping
        do_reset();
        bus.lock = '0;
        bus.req  = 3'b001;
        set_px(0, 160, 5, 2);
        cycle();
        chk("clip1_gnt", last_gnt, 1);
        set_px(0, 159, 119, 6);
        cycle();
        chk("clip1_plot", last_plot, CLIP ? 0 : 1);
        chk("clip1_cnt", last_clip, CLIP ? 1 : 0);
        bus.req = '0;
        cycle();
        chk("clip2_plot", last_plot, 1);
        chk("clip2_x", last_x, 159);
        chk("clip2_cnt", last_clip, CLIP ? 1 : 0);

        // reset mid-burst
        do_reset();
        bus.req  = 3'b100;
        bus.lock = 3'b100;
        set_px(2, 77, 33, 7);
        cycle();
        bus.req = 3'b111;
        for (int k = 0; k < 3; k++) cycle();
        chk("mid_owned", last_owned, 1);
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        bus.lock = '0;
        cycle();
        chk("mid_owned_clr", last_owned, 0);
        chk("mid_plot_clr", last_plot, 0);
        chk("mid_x_clr", last_x, 0);
        chk("mid_gnt", last_gnt, 1);

        // randomized requesters
        do_reset();
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) pending[i] = 1'b0;
                if (!pending[i] && $urandom_range(0, 3) != 0) begin
                    pending[i] = 1'b1;
                    set_px(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
                end
                bus.req[i] = pending[i];
                if ($urandom_range(0, 7) == 0) bus.lock[i] = ($urandom_range(0, 2) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
